// File: rtl/fe_capture_mc_if.sv
// FIFO write port of the multi-channel front-end capture stage.
// master: capture stage (drives packets, observes FIFO status).
// slave:  capture FIFO (accepts packets, reports full/overflow-blocked).
interface fe_capture_mc_if #(
  parameter int pCH_ID_WIDTH          = 2,
  parameter int pTIMESTAMP_FULL_WIDTH = 16
);
  logic                             O_fifo_wr;
  logic [1:0]                       O_fifo_command;
  logic [pCH_ID_WIDTH-1:0]          O_fifo_channel;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time;
  logic                             I_fifo_full;
  logic                             I_fifo_overflow_blocked;

  modport master (
    output O_fifo_wr, O_fifo_command, O_fifo_channel, O_fifo_time,
    input  I_fifo_full, I_fifo_overflow_blocked
  );

  modport slave (
    input  O_fifo_wr, O_fifo_command, O_fifo_channel, O_fifo_time,
    output I_fifo_full, I_fifo_overflow_blocked
  );
endinterface

// File: rtl/fe_capture_mc.sv
// Multi-channel front-end capture stage: per-channel pending event bits are
// drained into one FIFO write port as channel-tagged DATA packets, with
// delta-TIME packets, capture-length limiting and backpressure handling.
// Optional macro FE_CAPTURE_DROP_COUNT_EN enables the saturating drop counter
// on O_drop_count; without it O_drop_count is tied to zero.
module fe_capture_mc #(
  parameter int pNUM_CH               = 4,
  parameter int pCH_ID_WIDTH          = 2,
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCAPTURE_LEN_WIDTH    = 24,
  parameter int pDROP_CTR_WIDTH       = 16
) (
  input  logic                             fe_clk,
  input  logic                             reset_n,
  input  logic [pNUM_CH-1:0]               I_event,
  input  logic [2*pNUM_CH-1:0]             I_data_cmd,
  input  logic [pNUM_CH-1:0]               I_ch_enable,
  input  logic                             I_capture_enable,
  input  logic                             I_arm,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len,
  input  logic                             I_count_writes,
  input  logic                             I_counter_quick_start,
  input  logic                             I_timestamps_disable,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_max_short_timestamp,
  fe_capture_mc_if.master                  fifo,
  output logic                             O_capturing,
  output logic                             O_capture_done,
  output logic [pDROP_CTR_WIDTH-1:0]       O_drop_count
);

  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b01;
  localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TS_KEEPALIVE =
    {{(pTIMESTAMP_FULL_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TIME = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                           r_state;
  logic [pNUM_CH-1:0]               r_pend;
  logic [2*pNUM_CH-1:0]             r_cmd;
  logic                             r_ctr_running;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] r_ts;
  logic [pCAPTURE_LEN_WIDTH-1:0]    r_count;
  logic                             r_arm_d;
  logic                             r_fifo_wr;
  logic [1:0]                       r_fifo_cmd;
  logic [pCH_ID_WIDTH-1:0]          r_fifo_ch;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] r_fifo_time;
  logic                             r_capturing;
  logic                             r_capture_done;

  logic [pNUM_CH-1:0]               w_event_req;
  logic [pNUM_CH-1:0]               w_accept;
  logic [pNUM_CH-1:0]               w_clr;
  logic [pNUM_CH-1:0]               w_sel_onehot;
  logic [pCH_ID_WIDTH-1:0]          w_sel_ch;
  logic [1:0]                       w_sel_cmd;
  logic                             w_pend_any;
  logic                             w_len_ok;
  logic                             w_capture_allowed;
  logic                             w_ts_short;
  logic                             w_arm_rise;
  logic                             w_do_data;
  logic                             w_do_time;
  logic                             w_write;

  assign w_event_req       = I_event & I_ch_enable & {pNUM_CH{I_capture_enable}};
  assign w_pend_any        = |r_pend;
  assign w_len_ok          = (I_capture_len == '0) || (r_count < I_capture_len);
  assign w_capture_allowed = I_capture_enable && w_len_ok &&
                             !fifo.I_fifo_full && !fifo.I_fifo_overflow_blocked;
  assign w_ts_short        = (r_ts <= I_max_short_timestamp) || I_timestamps_disable;
  assign w_arm_rise        = I_arm && !r_arm_d;
  assign w_write           = w_do_data || w_do_time;
  assign w_clr             = w_do_data ? w_sel_onehot : '0;
  // A bit cleared on this edge can be re-set by a new event (set wins).
  assign w_accept          = w_event_req & (~r_pend | w_clr);

  // Lowest-index pending channel: scan high to low so the lowest hit lands last.
  always_comb begin
    w_sel_ch     = '0;
    w_sel_cmd    = '0;
    w_sel_onehot = '0;
    for (int unsigned i = pNUM_CH; i > 0; i--) begin
      if (r_pend[i-1]) begin
        w_sel_ch          = pCH_ID_WIDTH'(i-1);
        w_sel_cmd         = r_cmd[2*(i-1) +: 2];
        w_sel_onehot      = '0;
        w_sel_onehot[i-1] = 1'b1;
      end
    end
  end

  // Packet decision for this edge; the state register names the packet on the port.
  always_comb begin
    w_do_data = 1'b0;
    w_do_time = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pend_any && w_capture_allowed) begin
          if (w_ts_short) w_do_data = 1'b1;
          else            w_do_time = 1'b1;
        end else if (!w_pend_any && (r_ts == TS_KEEPALIVE) && !I_timestamps_disable) begin
          w_do_time = 1'b1;
        end
      end
      S_TIME, S_DATA: w_do_data = w_pend_any && w_capture_allowed;
      default: ;
    endcase
  end

  // Pending bits and latched per-channel commands.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_cmd  <= '0;
    end else begin
      if (!I_capture_enable) r_pend <= '0;
      else                   r_pend <= (r_pend & ~w_clr) | w_accept;
      for (int unsigned i = 0; i < pNUM_CH; i++) begin
        if (w_accept[i]) r_cmd[2*i +: 2] <= I_data_cmd[2*i +: 2];
      end
    end
  end

  // Timestamp counter: runs after quick start or first accepted event, reloads on writes.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctr_running <= 1'b0;
      r_ts          <= '0;
    end else begin
      if (!I_capture_enable)                         r_ctr_running <= 1'b0;
      else if (I_counter_quick_start || |w_accept)   r_ctr_running <= 1'b1;

      if (w_write)             r_ts <= '0;
      else if (!r_ctr_running) r_ts <= '0;
      else if (r_ts != '1)     r_ts <= r_ts + pTIMESTAMP_FULL_WIDTH'(1);
    end
  end

  // Capture length counter and capture status flags.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_d        <= 1'b0;
      r_count        <= '0;
      r_capturing    <= 1'b0;
      r_capture_done <= 1'b1;
    end else begin
      r_arm_d        <= I_arm;
      r_capturing    <= w_capture_allowed;
      r_capture_done <= !(I_arm || w_capture_allowed);
      if (w_arm_rise) begin
        r_count <= '0;
      end else if ((I_count_writes ? r_fifo_wr : I_capture_enable) && (r_count != '1)) begin
        r_count <= r_count + pCAPTURE_LEN_WIDTH'(1);
      end
    end
  end

  // Packet FSM with registered FIFO outputs.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fifo_wr   <= 1'b0;
      r_fifo_cmd  <= '0;
      r_fifo_ch   <= '0;
      r_fifo_time <= '0;
    end else if (w_do_data) begin
      r_state     <= S_DATA;
      r_fifo_wr   <= 1'b1;
      r_fifo_cmd  <= w_sel_cmd;
      r_fifo_ch   <= w_sel_ch;
      r_fifo_time <= r_ts;
    end else if (w_do_time) begin
      r_state     <= S_TIME;
      r_fifo_wr   <= 1'b1;
      r_fifo_cmd  <= FE_FIFO_CMD_TIME;
      r_fifo_ch   <= '0;
      r_fifo_time <= r_ts;
    end else begin
      r_state     <= S_IDLE;
      r_fifo_wr   <= 1'b0;
    end
  end

  assign fifo.O_fifo_wr      = r_fifo_wr;
  assign fifo.O_fifo_command = r_fifo_cmd;
  assign fifo.O_fifo_channel = r_fifo_ch;
  assign fifo.O_fifo_time    = r_fifo_time;
  assign O_capturing         = r_capturing;
  assign O_capture_done      = r_capture_done;

`ifdef FE_CAPTURE_DROP_COUNT_EN
  logic [pNUM_CH-1:0]           w_dropped;
  logic [pDROP_CTR_WIDTH:0]     w_drop_n;
  logic [pDROP_CTR_WIDTH:0]     w_drop_sum;
  logic [pDROP_CTR_WIDTH-1:0]   r_drop_count;

  assign w_dropped = w_event_req & r_pend & ~w_clr;

  // Number of events dropped this cycle, added to the current count with a carry bit.
  always_comb begin
    w_drop_n = '0;
    for (int unsigned i = 0; i < pNUM_CH; i++) begin
      w_drop_n = w_drop_n + (pDROP_CTR_WIDTH+1)'(w_dropped[i]);
    end
    w_drop_sum = {1'b0, r_drop_count} + w_drop_n;
  end

  // Saturating drop counter, cleared on the arm rising edge.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n)                        r_drop_count <= '0;
    else if (w_arm_rise)                 r_drop_count <= '0;
    else if (w_drop_sum[pDROP_CTR_WIDTH]) r_drop_count <= '1;
    else                                 r_drop_count <= w_drop_sum[pDROP_CTR_WIDTH-1:0];
  end

  assign O_drop_count = r_drop_count;
`else
  assign O_drop_count = '0;
`endif

endmodule

// File: tb/tb_fe_capture_mc.sv
// Directed testbench for fe_capture_mc (default 4-channel configuration).
module tb_fe_capture_mc;
  logic        fe_clk;
  logic        reset_n;
  logic [3:0]  I_event;
  logic [7:0]  I_data_cmd;
  logic [3:0]  I_ch_enable;
  logic        I_capture_enable;
  logic        I_arm;
  logic [23:0] I_capture_len;
  logic        I_count_writes;
  logic        I_counter_quick_start;
  logic        I_timestamps_disable;
  logic [15:0] I_max_short_timestamp;
  logic        O_capturing;
  logic        O_capture_done;
  logic [15:0] O_drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int wsum;

  fe_capture_mc_if #(.pCH_ID_WIDTH(2), .pTIMESTAMP_FULL_WIDTH(16)) fifo_if ();

  fe_capture_mc #(
    .pNUM_CH(4), .pCH_ID_WIDTH(2), .pTIMESTAMP_FULL_WIDTH(16),
    .pCAPTURE_LEN_WIDTH(24), .pDROP_CTR_WIDTH(16)
  ) dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_event(I_event), .I_data_cmd(I_data_cmd),
    .I_ch_enable(I_ch_enable), .I_capture_enable(I_capture_enable), .I_arm(I_arm),
    .I_capture_len(I_capture_len), .I_count_writes(I_count_writes),
    .I_counter_quick_start(I_counter_quick_start),
    .I_timestamps_disable(I_timestamps_disable),
    .I_max_short_timestamp(I_max_short_timestamp), .fifo(fifo_if),
    .O_capturing(O_capturing), .O_capture_done(O_capture_done),
    .O_drop_count(O_drop_count)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic tick_count();
    tick();
    wsum += int'(fifo_if.O_fifo_wr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [1:0] cmd, input logic [1:0] ch,
                         input logic [15:0] tm);
    chk({tag, "_wr"},   32'(fifo_if.O_fifo_wr), 1);
    chk({tag, "_cmd"},  32'(fifo_if.O_fifo_command), 32'(cmd));
    chk({tag, "_ch"},   32'(fifo_if.O_fifo_channel), 32'(ch));
    chk({tag, "_time"}, 32'(fifo_if.O_fifo_time), 32'(tm));
  endtask

  task automatic set_defaults();
    I_event = '0; I_data_cmd = '0; I_ch_enable = 4'hF; I_capture_enable = 1'b0;
    I_arm = 1'b0; I_capture_len = '0; I_count_writes = 1'b1;
    I_counter_quick_start = 1'b0; I_timestamps_disable = 1'b0;
    I_max_short_timestamp = 16'hFFFF;
    fifo_if.I_fifo_full = 1'b0; fifo_if.I_fifo_overflow_blocked = 1'b0;
  endtask

  task automatic do_reset();
    set_defaults();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    set_defaults();
    reset_n = 1'b0;
    tick();
    chk("rst_wr",      32'(fifo_if.O_fifo_wr), 0);
    chk("rst_cmd",     32'(fifo_if.O_fifo_command), 0);
    chk("rst_ch",      32'(fifo_if.O_fifo_channel), 0);
    chk("rst_time",    32'(fifo_if.O_fifo_time), 0);
    chk("rst_capt",    32'(O_capturing), 0);
    chk("rst_done",    32'(O_capture_done), 1);
    chk("rst_drop",    32'(O_drop_count), 0);

    // Single event: ch2 cmd 01, delta 5
    do_reset();
    I_capture_enable = 1'b1; I_counter_quick_start = 1'b1; I_max_short_timestamp = 16'd10;
    tick();
    chk("single_capturing", 32'(O_capturing), 1);
    chk("single_done",      32'(O_capture_done), 0);
    repeat (4) tick();
    I_event = 4'b0100; I_data_cmd = 8'h10;
    tick();
    chk("single_lat_wr", 32'(fifo_if.O_fifo_wr), 0);
    I_event = '0;
    tick();
    chk_pkt("single", 2'b01, 2'd2, 16'd5);
    tick();
    chk("single_pulse_wr", 32'(fifo_if.O_fifo_wr), 0);

    // Simultaneous events on ch0, ch1, ch3
    do_reset();
    I_capture_enable = 1'b1; I_counter_quick_start = 1'b1;
    tick();
    tick();
    I_event = 4'b1011; I_data_cmd = 8'h4B;
    tick();
    I_event = '0;
    tick();
    chk_pkt("multi0", 2'b11, 2'd0, 16'd2);
    tick();
    chk_pkt("multi1", 2'b10, 2'd1, 16'd0);
    tick();
    chk_pkt("multi3", 2'b01, 2'd3, 16'd0);
    tick();
    chk("multi_end_wr", 32'(fifo_if.O_fifo_wr), 0);

    // Long idle: TIME 300 then DATA 0
    do_reset();
    I_capture_enable = 1'b1; I_counter_quick_start = 1'b1; I_max_short_timestamp = 16'd7;
    tick();
    repeat (299) tick();
    I_event = 4'b0010; I_data_cmd = 8'h08;
    tick();
    chk("idle_lat_wr", 32'(fifo_if.O_fifo_wr), 0);
    I_event = '0;
    tick();
    chk_pkt("idle_time", 2'b01, 2'd0, 16'd300);
    tick();
    chk_pkt("idle_data", 2'b10, 2'd1, 16'd0);
    tick();
    chk("idle_end_wr", 32'(fifo_if.O_fifo_wr), 0);

    // Long idle with timestamps disabled: DATA only, carrying the full delta
    do_reset();
    I_capture_enable = 1'b1; I_counter_quick_start = 1'b1; I_max_short_timestamp = 16'd7;
    I_timestamps_disable = 1'b1;
    tick();
    repeat (299) tick();
    I_event = 4'b0010; I_data_cmd = 8'h08;
    tick();
    I_event = '0;
    tick();
    chk_pkt("tsdis_data", 2'b10, 2'd1, 16'd300);
    tick();
    chk("tsdis_end_wr", 32'(fifo_if.O_fifo_wr), 0);

    // Keepalive TIME at 0xFFFE, then timestamp reload
    do_reset();
    I_capture_enable = 1'b1; I_counter_quick_start = 1'b1;
    tick();
    wsum = 0;
    repeat (65534) tick_count();
    chk("keep_quiet_writes", 32'(wsum), 0);
    tick();
    chk_pkt("keep_time", 2'b01, 2'd0, 16'hFFFE);
    tick();
    chk("keep_pulse_wr", 32'(fifo_if.O_fifo_wr), 0);
    I_event = 4'b0001; I_data_cmd = 8'h03;
    tick();
    I_event = '0;
    tick();
    chk_pkt("keep_reload", 2'b11, 2'd0, 16'd2);

    // Length limit: len 4, count writes, 10 events -> 5 writes (one overshoot)
    do_reset();
    I_capture_enable = 1'b1; I_capture_len = 24'd4; I_count_writes = 1'b1; I_arm = 1'b1;
    tick();
    wsum = 0;
    for (int k = 1; k <= 20; k++) begin
      case (k)
        1:       I_event = 4'hF;
        2:       I_event = 4'h1;
        7:       I_event = 4'hF;
        8:       I_event = 4'h2;
        default: I_event = 4'h0;
      endcase
      tick_count();
    end
    I_event = '0;
    chk("len_writes",    32'(wsum), 5);
    chk("len_capturing", 32'(O_capturing), 0);
    chk("len_done_armed", 32'(O_capture_done), 0);
`ifdef FE_CAPTURE_DROP_COUNT_EN
    chk("len_drop", 32'(O_drop_count), 1);
`else
    chk("len_drop", 32'(O_drop_count), 0);
`endif
    I_arm = 1'b0;
    tick();
    chk("len_done", 32'(O_capture_done), 1);
    I_arm = 1'b1;
    tick();
    chk("rearm_wr0",  32'(fifo_if.O_fifo_wr), 0);
    chk("rearm_done", 32'(O_capture_done), 0);
    tick();
    chk("rearm_wr",        32'(fifo_if.O_fifo_wr), 1);
    chk("rearm_ch",        32'(fifo_if.O_fifo_channel), 0);
    chk("rearm_capturing", 32'(O_capturing), 1);
    chk("rearm_drop",      32'(O_drop_count), 0);

    // Backpressure: FIFO full 20 cycles, ch1 fires twice
    do_reset();
    I_capture_enable = 1'b1; fifo_if.I_fifo_full = 1'b1;
    wsum = 0;
    tick_count();
    I_event = 4'b0010; I_data_cmd = 8'h08;
    tick_count();
    I_event = '0;
    repeat (4) tick_count();
    I_event = 4'b0010;
    tick_count();
    I_event = '0;
    repeat (13) tick_count();
    chk("bp_full_writes", 32'(wsum), 0);
    chk("bp_capturing",   32'(O_capturing), 0);
    fifo_if.I_fifo_full = 1'b0;
    tick();
    chk_pkt("bp_release", 2'b10, 2'd1, 16'd18);
    tick();
    chk("bp_end_wr", 32'(fifo_if.O_fifo_wr), 0);
`ifdef FE_CAPTURE_DROP_COUNT_EN
    chk("bp_drop", 32'(O_drop_count), 1);
`else
    chk("bp_drop", 32'(O_drop_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
